// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C transaction sequencer.
package i2c_pkg;

  // Sequencer control states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_XFER   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_ABORT  = 3'd4
  } seq_state_t;

  // Largest byte count one transaction may carry (fits the 3-bit word count).
  localparam int I2C_MAX_WORDS = 7;

  // Default launch-to-finish cycle budget.
  localparam logic [15:0] I2C_DEFAULT_TIMEOUT = 16'd50000;

endpackage

// File: rtl/i2c_byte_fifo.sv
// Byte FIFO with wide pointers, simultaneous push/pop and a one-cycle flush.
module i2c_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_nrst,
  input  logic                     i_push,
  input  logic [7:0]               i_wdata,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [7:0]               o_head
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic        push_ok;
  logic        pop_ok;

  assign o_count = wptr_q - rptr_q;
  assign o_full  = (o_count == FULL_CNT);
  assign o_empty = (o_count == '0);
  assign o_head  = mem_q[rptr_q[AW-1:0]];
  assign push_ok = i_push && !o_full;
  assign pop_ok  = i_pop && !o_empty;

  // Next pointer values; a flush discards everything stored before this cycle.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_ok) begin
      wptr_d = wptr_q + 1'b1;
    end else begin
      wptr_d = wptr_q;
    end
    if (i_flush) begin
      rptr_d = wptr_q;
    end else if (pop_ok) begin
      rptr_d = rptr_q + 1'b1;
    end else begin
      rptr_d = rptr_q;
    end
  end

  // Pointer and storage registers; storage clears on reset so the head reads 0.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      if (push_ok) begin
        mem_q[wptr_q[AW-1:0]] <= i_wdata;
      end
    end
  end

endmodule

// File: rtl/i2c_txn_sequencer.sv
// Host-side front end: buffers write bytes, launches the I2C controller,
// steps bytes on each ACK and reports done / NACK / timeout.
module i2c_txn_sequencer
  import i2c_pkg::*;
#(
  parameter int          DEPTH   = 8,
  parameter logic [15:0] TIMEOUT = I2C_DEFAULT_TIMEOUT
) (
  input  logic       i_clk,
  input  logic       i_nrst,
  input  logic       i_wr_en,
  input  logic [7:0] i_wdata,
  input  logic       i_go,
  input  logic [6:0] i_addr,
  input  logic       i_rw,
  output logic       o_full,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err,
  output logic       o_start,
  output logic [6:0] o_addr,
  output logic       o_rw,
  output logic [2:0] o_word_cnt,
  output logic [7:0] o_data,
  input  logic       i_byte_ack,
  input  logic       i_nack,
  input  logic       i_finished
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] MAX_CNT = (AW + 1)'(I2C_MAX_WORDS);

  seq_state_t  state_q, state_d;
  logic [15:0] tmo_q, tmo_d, tmo_inc;
  logic [2:0]  rem_q, rem_d;
  logic [6:0]  addr_q, addr_d;
  logic        rw_q, rw_d;
  logic [2:0]  wcnt_q, wcnt_d;
  logic        start_q, start_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;

  logic        fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [AW:0] fifo_count;
  logic        count_ok, tmo_hit;

  i2c_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_nrst  (i_nrst),
    .i_push  (i_wr_en),
    .i_wdata (i_wdata),
    .i_pop   (fifo_pop),
    .i_flush (fifo_flush),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count),
    .o_head  (o_data)
  );

  // Commit only with 1..I2C_MAX_WORDS bytes buffered.
  assign count_ok = (fifo_count != '0) && (fifo_count <= MAX_CNT);
  // The counter reaches TIMEOUT on this cycle's increment.
  assign tmo_hit  = ({1'b0, tmo_q} + 17'd1) >= {1'b0, TIMEOUT};
  assign tmo_inc  = (tmo_q == 16'hFFFF) ? tmo_q : tmo_q + 16'd1;

  // Next-state, launch latches and pulse outputs (pulses are registered, so they
  // are raised on the transition into the state they belong to).
  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    rem_d      = rem_q;
    addr_d     = addr_q;
    rw_d       = rw_q;
    wcnt_d     = wcnt_q;
    start_d    = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_go && count_ok) begin
          addr_d  = i_addr;
          rw_d    = i_rw;
          wcnt_d  = fifo_count[2:0];
          rem_d   = fifo_count[2:0];
          start_d = 1'b1;
          state_d = ST_LAUNCH;
        end else if (i_go) begin
          err_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        tmo_d   = 16'd0;
        state_d = ST_XFER;
      end
      ST_XFER: begin
        tmo_d = tmo_inc;
        if (i_nack || tmo_hit) begin
          err_d   = 1'b1;
          state_d = ST_ABORT;
        end else if (i_byte_ack && !fifo_empty) begin
          fifo_pop = 1'b1;
          rem_d    = rem_q - 3'd1;
          if (rem_q == 3'd1) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_XFER;
          end
        end else begin
          state_d = ST_XFER;
        end
      end
      ST_DRAIN: begin
        tmo_d = tmo_inc;
        if (i_nack || tmo_hit) begin
          err_d   = 1'b1;
          state_d = ST_ABORT;
        end else if (i_finished) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_ABORT: begin
        fifo_flush = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State, counters, latches and registered outputs.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= ST_IDLE;
      tmo_q   <= 16'd0;
      rem_q   <= 3'd0;
      addr_q  <= 7'd0;
      rw_q    <= 1'b0;
      wcnt_q  <= 3'd0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      rem_q   <= rem_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wcnt_q  <= wcnt_d;
      start_q <= start_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign o_full     = fifo_full;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_err      = err_q;
  assign o_start    = start_q;
  assign o_addr     = addr_q;
  assign o_rw       = rw_q;
  assign o_word_cnt = wcnt_q;

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic against a
// queue-based transaction model.
module tb_i2c_txn_sequencer;
  localparam int          DEPTH = 8;
  localparam logic [15:0] TMO   = 16'd20;

  logic       i_clk = 1'b0;
  logic       i_nrst = 1'b0;
  logic       i_wr_en = 1'b0, i_go = 1'b0, i_rw = 1'b0;
  logic [7:0] i_wdata = 8'h00;
  logic [6:0] i_addr = 7'h00;
  logic       i_byte_ack = 1'b0, i_nack = 1'b0, i_finished = 1'b0;
  logic       o_full, o_busy, o_done, o_err, o_start, o_rw;
  logic [6:0] o_addr;
  logic [2:0] o_word_cnt;
  logic [7:0] o_data;

  int n_cmp = 0;
  int n_bad = 0;

  i2c_txn_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_wr_en(i_wr_en), .i_wdata(i_wdata),
    .i_go(i_go), .i_addr(i_addr), .i_rw(i_rw), .o_full(o_full), .o_busy(o_busy),
    .o_done(o_done), .o_err(o_err), .o_start(o_start), .o_addr(o_addr),
    .o_rw(o_rw), .o_word_cnt(o_word_cnt), .o_data(o_data),
    .i_byte_ack(i_byte_ack), .i_nack(i_nack), .i_finished(i_finished)
  );

  always #5 i_clk = ~i_clk;

  // ---------------- reference model ----------------
  localparam int P_IDLE = 0, P_LAUNCH = 1, P_XFER = 2, P_DRAIN = 3, P_ABORT = 4;
  logic [7:0] m_q[$];
  int         m_phase = P_IDLE;
  int         m_left = 0;
  int         m_age = 0;
  logic [6:0] m_addr = 7'h00;
  logic       m_rw = 1'b0;
  logic [2:0] m_wc = 3'd0;
  logic       e_start = 1'b0, e_done = 1'b0, e_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_phase = P_IDLE; m_left = 0; m_age = 0;
    m_addr = 7'h00; m_rw = 1'b0; m_wc = 3'd0;
    e_start = 1'b0; e_done = 1'b0; e_err = 1'b0;
  endtask

  // Advance the model by one clock using the inputs that the DUT just sampled.
  task automatic model_step();
    int  sz = m_q.size();
    bit  push_ok = i_wr_en && (sz < DEPTH);
    bit  expired = (m_age + 1) >= int'(TMO);
    e_start = 1'b0; e_done = 1'b0; e_err = 1'b0;
    case (m_phase)
      P_IDLE: if (i_go) begin
        if (sz >= 1 && sz <= 7) begin
          m_addr = i_addr; m_rw = i_rw; m_wc = 3'(sz); m_left = sz;
          e_start = 1'b1; m_phase = P_LAUNCH;
        end else e_err = 1'b1;
      end
      P_LAUNCH: begin m_age = 0; m_phase = P_XFER; end
      P_XFER, P_DRAIN: begin
        if (i_nack || expired) begin
          e_err = 1'b1; m_phase = P_ABORT;
        end else if (m_phase == P_XFER && i_byte_ack && sz > 0) begin
          void'(m_q.pop_front());
          m_left--;
          if (m_left == 0) m_phase = P_DRAIN;
        end else if (m_phase == P_DRAIN && i_finished) begin
          e_done = 1'b1; m_phase = P_IDLE;
        end
        if (m_age < 65535) m_age++;
      end
      P_ABORT: begin m_q.delete(); m_phase = P_IDLE; end
      default: m_phase = P_IDLE;
    endcase
    if (push_ok) m_q.push_back(i_wdata);
  endtask

  task automatic compare_all();
    check("start", o_start, e_start);
    check("done", o_done, e_done);
    check("err", o_err, e_err);
    check("busy", o_busy, m_phase != P_IDLE);
    check("full", o_full, m_q.size() == DEPTH);
    check("addr", o_addr, m_addr);
    check("rw", o_rw, m_rw);
    check("word_cnt", o_word_cnt, m_wc);
    if (m_q.size() > 0) check("data", o_data, m_q[0]);
  endtask

  task automatic tick();
    @(posedge i_clk); #1;
    model_step();
    compare_all();
  endtask

  task automatic idle_inputs();
    i_wr_en = 1'b0; i_go = 1'b0; i_byte_ack = 1'b0; i_nack = 1'b0; i_finished = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    i_nrst = 1'b0; #1;
    model_reset();
    check("rst_start", o_start, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_err", o_err, 1'b0);
    check("rst_done", o_done, 1'b0);
    check("rst_addr", o_addr, 7'h00);
    check("rst_wcnt", o_word_cnt, 3'd0);
    check("rst_data", o_data, 8'h00);
    check("rst_full", o_full, 1'b0);
    @(negedge i_clk); i_nrst = 1'b1;
  endtask

  task automatic push(input logic [7:0] b);
    i_wr_en = 1'b1; i_wdata = b; tick(); i_wr_en = 1'b0;
  endtask

  task automatic go(input logic [6:0] a, input logic rw);
    i_go = 1'b1; i_addr = a; i_rw = rw; tick(); i_go = 1'b0;
  endtask

  initial begin
    int n;
    apply_reset();

    // Basic 3-byte write.
    push(8'hA1); push(8'hB2); push(8'hC3);
    go(7'h50, 1'b0);
    check("t1_start", o_start, 1'b1);
    check("t1_wcnt", o_word_cnt, 3'd3);
    check("t1_addr", o_addr, 7'h50);
    tick();
    check("t1_d0", o_data, 8'hA1);
    i_byte_ack = 1'b1; tick(); check("t1_d1", o_data, 8'hB2);
    tick(); check("t1_d2", o_data, 8'hC3);
    tick(); i_byte_ack = 1'b0;
    i_finished = 1'b1; tick(); i_finished = 1'b0;
    check("t1_done", o_done, 1'b1);
    check("t1_busy", o_busy, 1'b0);
    check("t1_empty", m_q.size(), 0);

    // Rejected commits: empty, then full.
    go(7'h11, 1'b1);
    check("t2_err_empty", o_err, 1'b1);
    check("t2_nostart", o_start, 1'b0);
    for (int i = 0; i < 9; i++) push(8'(8'h10 + i));
    check("t2_full", o_full, 1'b1);
    go(7'h12, 1'b0);
    check("t2_err_full", o_err, 1'b1);
    check("t2_still_full", o_full, 1'b1);
    apply_reset();

    // NACK after first byte flushes the FIFO.
    push(8'h33); push(8'h44);
    go(7'h22, 1'b1);
    tick();
    i_byte_ack = 1'b1; tick(); i_byte_ack = 1'b0;
    i_nack = 1'b1; tick(); i_nack = 1'b0;
    check("t3_err", o_err, 1'b1);
    tick();
    check("t3_busy", o_busy, 1'b0);
    check("t3_flushed", o_full, 1'b0);
    go(7'h22, 1'b0);
    check("t3_err_after_flush", o_err, 1'b1);

    // Timeout with no controller response.
    push(8'h5A);
    go(7'h33, 1'b0);
    tick();                 // first XFER cycle
    n = 0;
    while (o_err !== 1'b1 && n < 60) begin tick(); n++; end
    check("t4_tmo_cycles", n, 20);
    tick();
    check("t4_idle", o_busy, 1'b0);

    // Full FIFO, then push + ack in the same XFER cycle.
    for (int i = 0; i < 9; i++) push(8'(8'h80 + i));
    check("t5_full", o_full, 1'b1);
    apply_reset();
    push(8'h01); push(8'h02); push(8'h03);
    go(7'h44, 1'b0);
    tick();
    i_byte_ack = 1'b1; i_wr_en = 1'b1; i_wdata = 8'h04; tick();
    i_byte_ack = 1'b0; i_wr_en = 1'b0;
    check("t5_size", m_q.size(), 3);
    check("t5_head", o_data, 8'h02);
    apply_reset();

    // Reset in the middle of XFER, then a clean transaction.
    push(8'h61); push(8'h62);
    go(7'h55, 1'b1);
    tick();
    #2;
    apply_reset();
    push(8'h77);
    go(7'h66, 1'b1);
    check("t6_start", o_start, 1'b1);
    tick();
    i_byte_ack = 1'b1; tick(); i_byte_ack = 1'b0;
    i_finished = 1'b1; tick(); i_finished = 1'b0;
    check("t6_done", o_done, 1'b1);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if (m_phase == P_IDLE && m_q.size() == DEPTH) begin
        apply_reset();
      end
      i_wr_en    = ($urandom_range(99) < (m_q.size() < 6 ? 40 : 5));
      i_wdata    = 8'($urandom);
      i_go       = ($urandom_range(99) < 10);
      i_addr     = 7'($urandom);
      i_rw       = 1'($urandom);
      i_byte_ack = ($urandom_range(99) < 35);
      i_nack     = ($urandom_range(99) < 3);
      i_finished = ($urandom_range(99) < 20);
      tick();
    end
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_txn_sequencer.md
# i2c_txn_sequencer

Host-side front end for the I2C master controller. Buffers host write bytes in a small FIFO, latches address and direction on commit, and launches the controller with a start pulse. It then presents one data byte at a time as the controller acknowledges each byte, and reports completion, NACK or timeout back to the host.

## Interface
- DEPTH, 8: byte FIFO depth; must be a power of two, ≥ 8.
- TIMEOUT, 16'd50000: maximum cycles from launch to `i_finished` before abort.
- i_clk  in  1  clock
- i_nrst  in  1  asynchronous, active-low reset
- i_wr_en  in  1  host pushes `i_wdata` into FIFO (ignored when `o_full`)
- i_wdata  in  8  host data byte
- i_go  in  1  commit pulse: launch transaction with current FIFO contents
- i_addr  in  7  7-bit slave address, sampled on accepted `i_go`
- i_rw  in  1  direction bit, sampled on accepted `i_go`
- o_full  out  1  FIFO full
- o_busy  out  1  transaction in flight (not IDLE)
- o_done  out  1  one-cycle pulse: transaction ended OK
- o_err  out  1  one-cycle pulse: rejected commit, NACK or timeout
- o_start  out  1  one-cycle launch pulse to controller
- o_addr  out  7  latched address to controller
- o_rw  out  1  latched direction
- o_word_cnt  out  3  latched byte count (1..7)
- o_data  out  8  current byte (FIFO head) to controller
- i_byte_ack  in  1  controller pulse: current byte sent and ACKed
- i_nack  in  1  controller pulse: slave NACKed
- i_finished  in  1  controller pulse: STOP issued

## Operation
- FIFO: registered read/write pointers one bit wider than log2(DEPTH); count = wptr − rptr. Full when count == DEPTH. Push and pop in the same cycle are both honoured.
- The FIFO head is always visible on `o_data`.
- States are IDLE, LAUNCH, XFER, DRAIN, ABORT.
- IDLE:
  - `i_go` with count in 1..7: latch `i_addr`, `i_rw` and count into `o_word_cnt`, then go to LAUNCH.
  - `i_go` with count 0 or ≥ 8: pulse `o_err`, stay in IDLE, FIFO untouched.
- LAUNCH: assert `o_start` for this single cycle, clear the timeout counter, go to XFER.
- XFER:
  - `i_byte_ack` pops one byte and decrements the remaining counter.
  - When remaining reaches 0, go to DRAIN.
  - `i_nack` goes to ABORT.
- DRAIN:
  - `i_finished` pulses `o_done` and returns to IDLE.
  - `i_nack` goes to ABORT.
- ABORT: flush the FIFO (rptr ← wptr), pulse `o_err`, return to IDLE next cycle.
- Timeout: in XFER or DRAIN, a 16-bit counter increments every cycle. Reaching TIMEOUT goes to ABORT. The counter saturates and does not wrap.
- Pushes are accepted in every state, including during a transfer, subject to `o_full`.
- `i_go` outside IDLE is ignored with no error.

## Timing
- Reset values:
  - `o_start`, `o_done`, `o_err`, `o_busy` = 0.
  - `o_addr` = 0, `o_rw` = 0, `o_word_cnt` = 0.
  - `o_data` = 0 (empty FIFO storage reset to 0).
  - pointers = 0; state = IDLE.
- `i_go` at cycle N: `o_start` = 1 at N+1, `o_busy` = 1 from N+1.
- `i_byte_ack` at cycle M: next byte on `o_data` at M+1.
- `i_finished` at cycle F: `o_done` at F+1, `o_busy` = 0 at F+1.
- All outputs are registered; no combinational path from inputs to outputs except `o_data` (FIFO head mux from registered pointer).
- Same-cycle precedence:
  - `i_nack` beats `i_byte_ack` and `i_finished`.
  - Timeout beats everything except `i_nack` (both go to ABORT; one `o_err`).
- `i_byte_ack` in DRAIN, or in an empty FIFO, is ignored.
- Reset asserted mid-transfer: immediate return to reset values; FIFO contents lost.

## Structure
- Shared package `i2c_pkg`: state enum `seq_state_t`, `I2C_MAX_WORDS` = 7, default TIMEOUT constant.
- One sub-module: `i2c_byte_fifo` (parameter DEPTH; push, pop, flush, full, empty, count, head).
- The FSM, timeout counter and launch latches live in the top.

## Test plan
- Push 0xA1, 0xB2, 0xC3; `i_go` with addr 0x50, rw 0 → `o_start` one cycle later, `o_word_cnt` = 3, `o_addr` = 0x50. Three `i_byte_ack` pulses give `o_data` sequence A1, B2, C3. `i_finished` → `o_done`, FIFO empty.
- `i_go` with empty FIFO → `o_err` pulse, no `o_start`; 8 bytes pushed then `i_go` → `o_err`, count stays 8.
- 2-byte transaction, `i_nack` after the first `i_byte_ack` → `o_err`, FIFO flushed (count 0), `o_busy` = 0.
- TIMEOUT = 20, 1-byte launch, no controller response → `o_err` exactly 20 cycles after XFER entry, state IDLE.
- Fill to 8 (`o_full` = 1), 9th push ignored; push + `i_byte_ack` in the same cycle during XFER → count unchanged.
- Deassert `i_nrst` mid-XFER → all outputs at reset values, subsequent normal transaction succeeds.
